// File: rtl/toy_phy_rf_wb_arbiter_if.sv
// Writeback bus bundle: requester handshake, regfile stall, regfile write ports and wakeup broadcast.
// master = requester/regfile side, slave = the arbiter.
interface toy_phy_rf_wb_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int N_WR      = 2,
    parameter int PREG_W    = 7,
    parameter int REG_WIDTH = 64
);
    logic [N_REQ-1:0]                req_vld;
    logic [N_REQ-1:0][PREG_W-1:0]    req_preg;
    logic [N_REQ-1:0][REG_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                req_rdy;
    logic                            rf_stall;
    logic [N_WR-1:0]                 wr_en;
    logic [N_WR-1:0][PREG_W-1:0]     wr_preg;
    logic [N_WR-1:0][REG_WIDTH-1:0]  wr_data;
    logic [N_WR-1:0]                 wk_vld;
    logic [N_WR-1:0][PREG_W-1:0]     wk_preg;

    modport master (
        output req_vld, req_preg, req_data, rf_stall,
        input  req_rdy, wr_en, wr_preg, wr_data, wk_vld, wk_preg
    );

    modport slave (
        input  req_vld, req_preg, req_data, rf_stall,
        output req_rdy, wr_en, wr_preg, wr_data, wk_vld, wk_preg
    );
endinterface

// File: rtl/toy_phy_rf_wb_arbiter.sv
// Round-robin writeback arbiter: up to N_WR requesters per cycle win a physical regfile write port,
// with same-cycle destination conflicts skipped and one registered cycle from grant to write/wakeup.
module toy_phy_rf_wb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int N_WR      = 2,
    parameter int PREG_W    = 7,
    parameter int REG_WIDTH = 64,
    parameter int MODE      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    toy_phy_rf_wb_arbiter_if.slave        bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [N_WR-1:0]                wr_en_q, wr_en_d;
    logic [N_WR-1:0][PREG_W-1:0]    wr_preg_q, wr_preg_d;
    logic [N_WR-1:0][REG_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [N_REQ-1:0]               grant;
    logic [N_WR-1:0]                slot_vld;
    logic [N_WR-1:0][PREG_W-1:0]    slot_preg;
    logic [N_WR-1:0][REG_WIDTH-1:0] slot_data;
    logic [PTR_W-1:0]               idx;
    logic [PTR_W-1:0]               last_idx;
    logic                           conflict;
    int                             n_grant;

    // Scan from rr_ptr; the k-th winner in scan order fills write slot k.
    always_comb begin
        grant     = '0;
        slot_vld  = '0;
        slot_preg = '0;
        slot_data = '0;
        idx       = '0;
        last_idx  = '0;
        conflict  = 1'b0;
        n_grant   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx      = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
            conflict = 1'b0;
            for (int k = 0; k < N_WR; k++) begin
                if (slot_vld[k] && (slot_preg[k] == bus.req_preg[idx])) begin
                    conflict = 1'b1;
                end
            end
            if (!rst && !bus.rf_stall && bus.req_vld[idx] && !conflict && (n_grant < N_WR)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < N_WR; k++) begin
                    if (k == n_grant) begin
                        slot_vld[k]  = 1'b1;
                        slot_preg[k] = bus.req_preg[idx];
                        slot_data[k] = bus.req_data[idx];
                    end
                end
                n_grant  = n_grant + 1;
                last_idx = idx;
            end
        end
    end

    // A grant to the INT zero register is accepted but never written; idle ports keep their last value.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = '0;
        wr_preg_d = wr_preg_q;
        wr_data_d = wr_data_q;
        if (n_grant != 0) begin
            rr_ptr_d = (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
        end
        for (int k = 0; k < N_WR; k++) begin
            wr_en_d[k] = slot_vld[k] && !((MODE == 0) && (slot_preg[k] == '0));
            if (wr_en_d[k]) begin
                wr_preg_d[k] = slot_preg[k];
                wr_data_d[k] = slot_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= '0;
            wr_preg_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_preg_q <= wr_preg_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Masking with rst discards a write that was registered on the edge just before reset.
    assign bus.req_rdy = grant;
    assign bus.wr_en   = rst ? '0 : wr_en_q;
    assign bus.wr_preg = rst ? '0 : wr_preg_q;
    assign bus.wr_data = rst ? '0 : wr_data_q;
    assign bus.wk_vld  = rst ? '0 : wr_en_q;
    assign bus.wk_preg = rst ? '0 : wr_preg_q;
endmodule

// File: tb/tb_toy_phy_rf_wb_arbiter.sv
// Self-checking bench for toy_phy_rf_wb_arbiter: directed scenarios followed by random traffic,
// with a behavioural arbitration model feeding a per-cycle scoreboard of expected write-port contents.
module tb_toy_phy_rf_wb_arbiter;
    localparam int N_REQ     = 4;
    localparam int N_WR      = 2;
    localparam int PREG_W    = 7;
    localparam int REG_WIDTH = 64;
    localparam int MODE      = 0;
    localparam int BOUND     = (N_REQ + N_WR - 1) / N_WR;

    typedef struct packed {
        logic [N_WR-1:0]           en;
        logic [N_WR*PREG_W-1:0]    preg;
        logic [N_WR*REG_WIDTH-1:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst;

    toy_phy_rf_wb_arbiter_if #(
        .N_REQ(N_REQ), .N_WR(N_WR), .PREG_W(PREG_W), .REG_WIDTH(REG_WIDTH)
    ) bus ();

    toy_phy_rf_wb_arbiter #(
        .N_REQ(N_REQ), .N_WR(N_WR), .PREG_W(PREG_W), .REG_WIDTH(REG_WIDTH), .MODE(MODE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int                        total = 0;
    int                        bad   = 0;
    wr_exp_t                   sb[$];
    int                        m_ptr = 0;
    logic [N_WR*PREG_W-1:0]    m_hold_preg = '0;
    logic [N_WR*REG_WIDTH-1:0] m_hold_data = '0;
    logic [N_REQ-1:0]          exp_rdy = '0;
    int                        wait_cnt[N_REQ];
    int                        max_wait = 0;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_REQ-1:0][REG_WIDTH-1:0] mkData(input logic [REG_WIDTH-1:0] base);
        logic [N_REQ-1:0][REG_WIDTH-1:0] d;
        for (int i = 0; i < N_REQ; i++) d[i] = base + REG_WIDTH'(i);
        return d;
    endfunction

    // Compare outputs registered on the last edge, then predict this cycle's grants and push them.
    task automatic evalCycle();
        wr_exp_t          popped;
        wr_exp_t          ent;
        logic [PREG_W-1:0] gp[N_WR];
        logic [N_REQ-1:0] conf;
        int               cnt;
        int               last;
        int               r;
        logic             hit;

        popped = '0;
        if (sb.size() > 0) popped = sb.pop_front();
        else if (!rst) checkOutput("sb_underflow", 128'd1, 128'd0);
        if (rst) popped = '0;
        checkOutput("wr_en",   bus.wr_en,   popped.en);
        checkOutput("wr_preg", bus.wr_preg, popped.preg);
        checkOutput("wr_data", bus.wr_data, popped.data);
        checkOutput("wk_vld",  bus.wk_vld,  popped.en);
        checkOutput("wk_preg", bus.wk_preg, popped.preg);
        checkOutput("rr_ptr",  dut.rr_ptr_q, m_ptr);

        exp_rdy  = '0;
        conf     = '0;
        cnt      = 0;
        last     = 0;
        ent.en   = '0;
        ent.preg = m_hold_preg;
        ent.data = m_hold_data;
        if (!rst && !bus.rf_stall) begin
            for (int s = 0; s < N_REQ; s++) begin
                r = (m_ptr + s) % N_REQ;
                if (bus.req_vld[r] && cnt < N_WR) begin
                    hit = 1'b0;
                    for (int g = 0; g < cnt; g++) if (gp[g] == bus.req_preg[r]) hit = 1'b1;
                    if (hit) conf[r] = 1'b1;
                    else begin
                        exp_rdy[r] = 1'b1;
                        gp[cnt]    = bus.req_preg[r];
                        if (!(MODE == 0 && bus.req_preg[r] == '0)) begin
                            ent.en[cnt] = 1'b1;
                            ent.preg[cnt*PREG_W +: PREG_W]       = bus.req_preg[r];
                            ent.data[cnt*REG_WIDTH +: REG_WIDTH] = bus.req_data[r];
                        end
                        cnt++;
                        last = r;
                    end
                end
            end
        end
        checkOutput("req_rdy", bus.req_rdy, exp_rdy);

        if (!rst && !bus.rf_stall) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_vld[i] && !exp_rdy[i] && !conf[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end

        if (rst) begin
            m_ptr = 0;
            ent   = '0;
        end else if (cnt > 0) begin
            m_ptr = (last + 1) % N_REQ;
        end
        m_hold_preg = ent.preg;
        m_hold_data = ent.data;
        sb.push_back(ent);
    endtask

    task automatic applyStimulus(input logic rst_v, input logic stall_v, input logic [N_REQ-1:0] vld,
                                 input logic [N_REQ-1:0][PREG_W-1:0] pregs,
                                 input logic [N_REQ-1:0][REG_WIDTH-1:0] datas);
        @(posedge clk);
        #1;
        rst          = rst_v;
        bus.rf_stall = stall_v;
        bus.req_vld  = vld;
        bus.req_preg = pregs;
        bus.req_data = datas;
        @(negedge clk);
        evalCycle();
    endtask

    initial begin
        logic [N_REQ-1:0]                rv;
        logic [N_REQ-1:0][PREG_W-1:0]    rp;
        logic [N_REQ-1:0][REG_WIDTH-1:0] rd;
        logic                            rs;

        for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
        rst          = 1'b1;
        bus.rf_stall = 1'b0;
        bus.req_vld  = '0;
        bus.req_preg = '0;
        bus.req_data = '0;

        applyStimulus(1'b1, 1'b0, 4'b0000, '0, '0);
        applyStimulus(1'b1, 1'b0, 4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, mkData(64'h50));
        checkOutput("reset_rdy",   bus.req_rdy, 4'b0000);
        checkOutput("reset_wr_en", bus.wr_en, 2'b00);
        checkOutput("reset_ptr",   dut.rr_ptr_q, 0);

        // Four requesters, two ports: two grants per cycle, pointer wraps back to 0.
        applyStimulus(1'b0, 1'b0, 4'b1111, {7'd13, 7'd12, 7'd11, 7'd10}, mkData(64'h100));
        checkOutput("c0_rdy", bus.req_rdy, 4'b0011);
        applyStimulus(1'b0, 1'b0, 4'b1100, {7'd13, 7'd12, 7'd11, 7'd10}, mkData(64'h100));
        checkOutput("c1_rdy",     bus.req_rdy, 4'b1100);
        checkOutput("c1_wr_en",   bus.wr_en, 2'b11);
        checkOutput("c1_wr_preg", bus.wr_preg, {7'd11, 7'd10});
        checkOutput("c1_wr_data", bus.wr_data, {64'h101, 64'h100});
        applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
        checkOutput("c2_ptr",     dut.rr_ptr_q, 0);
        checkOutput("c2_wr_preg", bus.wr_preg, {7'd13, 7'd12});

        // Same destination from req0 and req2: req2 must wait a cycle.
        applyStimulus(1'b0, 1'b0, 4'b0101, {7'd0, 7'd20, 7'd0, 7'd20}, mkData(64'h200));
        checkOutput("cf_rdy0", bus.req_rdy, 4'b0001);
        applyStimulus(1'b0, 1'b0, 4'b0100, {7'd0, 7'd20, 7'd0, 7'd20}, mkData(64'h200));
        checkOutput("cf_rdy1", bus.req_rdy, 4'b0100);
        checkOutput("cf_en0",  bus.wr_en, 2'b01);
        applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
        checkOutput("cf_ptr",  dut.rr_ptr_q, 3);
        checkOutput("cf_en1",  bus.wr_en, 2'b01);
        checkOutput("cf_data", bus.wr_data[0], 64'h202);

        // Zero register write is accepted but suppressed.
        applyStimulus(1'b0, 1'b0, 4'b0010, '0, mkData(64'hFFFE));
        checkOutput("z_rdy", bus.req_rdy, 4'b0010);
        applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
        checkOutput("z_wr_en",  bus.wr_en, 2'b00);
        checkOutput("z_wk_vld", bus.wk_vld, 2'b00);
        checkOutput("z_ptr",    dut.rr_ptr_q, 2);

        // Three stalled cycles, then grants resume from the held pointer.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111, {7'd43, 7'd42, 7'd41, 7'd40}, mkData(64'h300));
            checkOutput("st_rdy",   bus.req_rdy, 4'b0000);
            checkOutput("st_ptr",   dut.rr_ptr_q, 2);
            checkOutput("st_wr_en", bus.wr_en, 2'b00);
        end
        applyStimulus(1'b0, 1'b0, 4'b1111, {7'd43, 7'd42, 7'd41, 7'd40}, mkData(64'h300));
        checkOutput("resume_rdy", bus.req_rdy, 4'b1100);

        // Reset right after a grant to preg 30 discards that write.
        applyStimulus(1'b0, 1'b0, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd30}, mkData(64'h400));
        checkOutput("g30_rdy", bus.req_rdy, 4'b0001);
        applyStimulus(1'b1, 1'b0, 4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, mkData(64'h500));
        checkOutput("r30_rdy",     bus.req_rdy, 4'b0000);
        checkOutput("r30_wr_en",   bus.wr_en, 2'b00);
        checkOutput("r30_wr_preg", bus.wr_preg, '0);
        checkOutput("r30_wr_data", bus.wr_data, '0);
        checkOutput("r30_wk_vld",  bus.wk_vld, 2'b00);
        applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
        checkOutput("pr_ptr",     dut.rr_ptr_q, 0);
        checkOutput("pr_wr_en",   bus.wr_en, 2'b00);
        checkOutput("pr_wr_preg", bus.wr_preg, '0);

        // Random traffic; a request is held until the model says it was accepted.
        rv = '0;
        rp = '0;
        rd = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!rv[i] || exp_rdy[i]) begin
                    rv[i] = ($urandom_range(0, 3) != 0);
                    rp[i] = PREG_W'($urandom_range(0, 15));
                    rd[i] = {$urandom, $urandom};
                end
            end
            rs = ($urandom_range(0, 9) == 0);
            applyStimulus(1'b0, rs, rv, rp, rd);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
        checkOutput("starve_bound", 128'(max_wait <= BOUND), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
